// File: rtl/rgb2y_coef_ctrl_if.sv
// ---------------------------------------------------------------------------
// rgb2y_coef_ctrl_if
// Host-side request/acknowledge bundle of the RGB-to-luma coefficient
// controller.
//   cfg_req_i  : single-cycle request pulse (host -> ctrl)
//   cfg_sel_i  : 00 BT.601, 01 BT.709, 10 custom, 11 G-only
//   cfg_kr_i   : custom Kr, signed Q1.17 (used only when sel=10)
//   cfg_kb_i   : custom Kb, signed Q1.17 (used only when sel=10)
//   cfg_ack_o  : one-cycle completion pulse (ctrl -> host)
//   cfg_err_o  : 1 = request rejected, valid only with cfg_ack_o
//   busy_o     : request pending
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface rgb2y_coef_ctrl_if;
    logic        cfg_req_i;
    logic [1:0]  cfg_sel_i;
    logic [17:0] cfg_kr_i;
    logic [17:0] cfg_kb_i;
    logic        cfg_ack_o;
    logic        cfg_err_o;
    logic        busy_o;

    modport master (
        output cfg_req_i, cfg_sel_i, cfg_kr_i, cfg_kb_i,
        input  cfg_ack_o, cfg_err_o, busy_o
    );

    modport slave (
        input  cfg_req_i, cfg_sel_i, cfg_kr_i, cfg_kb_i,
        output cfg_ack_o, cfg_err_o, busy_o
    );
endinterface

// File: rtl/rgb2y_coef_ctrl.sv
// ---------------------------------------------------------------------------
// rgb2y_coef_ctrl
// Owns the Kr/Kb coefficients (signed Q1.17) of the RGB-to-luma converter,
// Y = Kr(R-G) + Kb(B-G) + G. Host requests are validated and applied only on
// a rising edge of vs_i, so a frame is never converted with mixed
// coefficients.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   cfg          request bundle (rgb2y_coef_ctrl_if.slave)
//   vs_i         vertical sync of the converter input stream, active high
//   kr_o, kb_o   coefficients driven to the converter
//   apply_cnt_o  number of applied configurations (wraps)
//   timeout_o    (only with RGB2Y_CFG_TIMEOUT_EN) pulses with a forced apply
//
// Optional feature macro: RGB2Y_CFG_TIMEOUT_EN
//   Defined   : WAIT_VS forces an apply after TIMEOUT_CYC cycles without vs.
//   Undefined : WAIT_VS waits indefinitely for a vs rising edge.
// ---------------------------------------------------------------------------
module rgb2y_coef_ctrl #(
    parameter int TIMEOUT_CYC = 2000000,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rgb2y_coef_ctrl_if.slave        cfg,
    input  logic                    vs_i,
    output logic signed [17:0]      kr_o,
    output logic signed [17:0]      kb_o,
    output logic [CNT_W-1:0]        apply_cnt_o
`ifdef RGB2Y_CFG_TIMEOUT_EN
    ,output logic                   timeout_o
`endif
);

    localparam logic signed [17:0] KR_601 = 18'sd39191;
    localparam logic signed [17:0] KB_601 = 18'sd14942;
    localparam logic signed [17:0] KR_709 = 18'sd27866;
    localparam logic signed [17:0] KB_709 = 18'sd9463;
    localparam logic signed [18:0] SUM_MAX = 19'sd131072;  // 1.0 in Q1.17

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT_VS} state_t;

    state_t              r_state;
    logic                r_vs_d;
    logic [1:0]          r_sel;
    logic signed [17:0]  r_pend_kr;
    logic signed [17:0]  r_pend_kb;
    logic signed [18:0]  r_sum;
    logic signed [17:0]  r_kr;
    logic signed [17:0]  r_kb;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;

    logic                w_vs_rise;
    logic                w_invalid;
    logic                w_apply;
    logic signed [17:0]  w_sel_kr;
    logic signed [17:0]  w_sel_kb;

    assign w_vs_rise = vs_i & ~r_vs_d;

    // Only custom coefficients can be rejected; table entries are always legal.
    assign w_invalid = (r_sel == 2'b10) &&
                       (r_pend_kr[17] || r_pend_kb[17] || (r_sum > SUM_MAX));

    // Table lookup happens at request time so the pending registers always
    // hold the exact values to be applied.
    always_comb begin
        w_sel_kr = KR_601;
        w_sel_kb = KB_601;
        case (cfg.cfg_sel_i)
            2'b00: begin w_sel_kr = KR_601;        w_sel_kb = KB_601;        end
            2'b01: begin w_sel_kr = KR_709;        w_sel_kb = KB_709;        end
            2'b10: begin w_sel_kr = cfg.cfg_kr_i;  w_sel_kb = cfg.cfg_kb_i;  end
            default: begin w_sel_kr = '0;          w_sel_kb = '0;            end
        endcase
    end

`ifdef RGB2Y_CFG_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic            w_to_hit;

    assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_apply   = w_vs_rise | w_to_hit;
    assign timeout_o = r_timeout;
`else
    assign w_apply   = w_vs_rise;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vs_d    <= 1'b1;      // no false edge if vs_i is high at release
            r_sel     <= 2'b00;
            r_pend_kr <= '0;
            r_pend_kb <= '0;
            r_sum     <= '0;
            r_kr      <= KR_601;
            r_kb      <= KB_601;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef RGB2Y_CFG_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_vs_d <= vs_i;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
`ifdef RGB2Y_CFG_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // A request coinciding with an ack pulse is dropped.
                    if (cfg.cfg_req_i && !r_ack) begin
                        r_sel     <= cfg.cfg_sel_i;
                        r_pend_kr <= w_sel_kr;
                        r_pend_kb <= w_sel_kb;
                        r_sum     <= {cfg.cfg_kr_i[17], cfg.cfg_kr_i} +
                                     {cfg.cfg_kb_i[17], cfg.cfg_kb_i};
                        r_busy    <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // vs_rise here is deliberately ignored: apply waits for
                    // the next frame.
                    if (w_invalid) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
`ifdef RGB2Y_CFG_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        r_state <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (w_apply) begin
                        r_kr    <= r_pend_kr;
                        r_kb    <= r_pend_kb;
                        r_cnt   <= r_cnt + 1'b1;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef RGB2Y_CFG_TIMEOUT_EN
                        r_timeout <= ~w_vs_rise;
`endif
                    end
`ifdef RGB2Y_CFG_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kr_o          = r_kr;
    assign kb_o          = r_kb;
    assign apply_cnt_o   = r_cnt;
    assign cfg.cfg_ack_o = r_ack;
    assign cfg.cfg_err_o = r_err;
    assign cfg.busy_o    = r_busy;

endmodule

// File: tb/tb_rgb2y_coef_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rgb2y_coef_ctrl
// Table-driven and randomized checks of rgb2y_coef_ctrl against a small
// behavioural model of the coefficient rules. Inputs are driven and outputs
// sampled on the falling clock edge. Cycle n=1 is the first cycle after the
// request pulse; a rejection acks at n=2, an apply acks one cycle after the
// cycle in which vs_i rises (the rise must fall at n>=2).
// ---------------------------------------------------------------------------
module tb_rgb2y_coef_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               vs_i;
    logic signed [17:0] kr_o, kb_o;
    logic [15:0]        apply_cnt_o;
`ifdef RGB2Y_CFG_TIMEOUT_EN
    logic               timeout_o;
`endif

    rgb2y_coef_ctrl_if cfg_if();

    always #5 clk = ~clk;

`ifdef RGB2Y_CFG_TIMEOUT_EN
    rgb2y_coef_ctrl #(.TIMEOUT_CYC(100), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if), .vs_i(vs_i),
        .kr_o(kr_o), .kb_o(kb_o), .apply_cnt_o(apply_cnt_o),
        .timeout_o(timeout_o));
`else
    rgb2y_coef_ctrl #(.TIMEOUT_CYC(2000000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if), .vs_i(vs_i),
        .kr_o(kr_o), .kb_o(kb_o), .apply_cnt_o(apply_cnt_o));
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: coefficients currently in force and apply count.
    int m_kr  = 39191;
    int m_kb  = 14942;
    int m_cnt = 0;

    typedef struct {
        logic [1:0] sel;
        int kr, kb;
        int v1, v2, xr;      // vs rise cycles and stray-request cycle (0 = none)
        bit err;
        int ekr, ekb, en;    // expected outputs and ack cycle
    } vec_t;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Coefficient rules at the level of plain integer arithmetic.
    function automatic void model(input logic [1:0] sel, input int kr, input int kb,
                                  output bit err, output int ekr, output int ekb);
        err = 0; ekr = m_kr; ekb = m_kb;
        case (sel)
            2'd0: begin ekr = 39191; ekb = 14942; end
            2'd1: begin ekr = 27866; ekb = 9463;  end
            2'd2: begin
                if (kr < 0 || kb < 0 || kr + kb > 131072) err = 1;
                else begin ekr = kr; ekb = kb; end
            end
            default: begin ekr = 0; ekb = 0; end
        endcase
    endfunction

    task automatic txn(input string name, input logic [1:0] sel, input int kr,
                       input int kb, input int v1, input int v2, input int xr,
                       input bit err, input int ekr, input int ekb, input int en,
                       input bit exp_to);
        int n;
        bit got, hold_bad, idle_bad;
        int prev_kr, prev_kb;
        logic [17:0] t_kr, t_kb;
        prev_kr = m_kr; prev_kb = m_kb;
        t_kr = 18'(kr); t_kb = 18'(kb);
        got = 0; hold_bad = 0; idle_bad = 0;
        @(negedge clk);
        cfg_if.cfg_sel_i = sel; cfg_if.cfg_kr_i = t_kr; cfg_if.cfg_kb_i = t_kb;
        cfg_if.cfg_req_i = 1'b1; vs_i = 1'b0;
        @(negedge clk);
        cfg_if.cfg_req_i = 1'b0;
        // Scramble data so a late sampling of sel/kr/kb would show up.
        cfg_if.cfg_sel_i = ~sel; cfg_if.cfg_kr_i = ~t_kr; cfg_if.cfg_kb_i = ~t_kb;
        n = 1;
        while (n <= 200) begin
            got = cfg_if.cfg_ack_o;
`ifdef RGB2Y_CFG_TIMEOUT_EN
            if (got) chk({name, "_timeout"}, timeout_o, exp_to);
`endif
            cfg_if.cfg_req_i = (n == xr);
            vs_i = (n == v1) || (n == v2);
            if (got) break;
            if (cfg_if.busy_o !== 1'b1 || kr_o != prev_kr || kb_o != prev_kb)
                hold_bad = 1;
            @(negedge clk);
            n++;
        end
        chk({name, "_ack_cycle"}, got ? n : -1, en);
        chk({name, "_hold"}, hold_bad, 0);
        chk({name, "_err"}, cfg_if.cfg_err_o, err);
        if (!err) begin
            m_kr = ekr; m_kb = ekb; m_cnt = (m_cnt + 1) % 65536;
        end
        chk({name, "_kr"}, kr_o, m_kr);
        chk({name, "_kb"}, kb_o, m_kb);
        chk({name, "_cnt"}, apply_cnt_o, m_cnt);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_if.cfg_req_i = 1'b0; vs_i = 1'b0;
            if (cfg_if.cfg_ack_o !== 1'b0 || cfg_if.busy_o !== 1'b0) idle_bad = 1;
        end
        chk({name, "_idle_after"}, idle_bad, 0);
    endtask

    vec_t vt[11];

    initial begin
        bit err;
        int ekr, ekb, kr, kb, v1, xr;
        logic [1:0] sel;
        logic [17:0] t;
        bit stray;

        vt[0]  = '{2'b01, 0, 0, 50, 0, 0, 0, 27866, 9463, 51};
        vt[1]  = '{2'b10, 100000, 40000, 5, 0, 0, 1, 27866, 9463, 2};
        vt[2]  = '{2'b10, -5, 10, 5, 0, 0, 1, 27866, 9463, 2};
        vt[3]  = '{2'b10, 65536, 65536, 5, 0, 0, 0, 65536, 65536, 6};
        vt[4]  = '{2'b10, 65537, 65536, 4, 0, 0, 1, 65536, 65536, 2};
        vt[5]  = '{2'b10, 131071, 1, 2, 0, 0, 0, 131071, 1, 3};
        vt[6]  = '{2'b10, 0, -131072, 3, 0, 0, 1, 131071, 1, 2};
        vt[7]  = '{2'b11, 0, 0, 10, 0, 3, 0, 0, 0, 11};          // stray req while busy
        vt[8]  = '{2'b01, 0, 0, 1, 6, 0, 0, 27866, 9463, 7};     // vs rise during CHECK
        vt[9]  = '{2'b00, 0, 0, 4, 0, 5, 0, 39191, 14942, 5};    // stray req with ack
        vt[10] = '{2'b10, 12345, 67890, 8, 0, 0, 0, 12345, 67890, 9};

        rst = 1'b1; vs_i = 1'b0;
        cfg_if.cfg_req_i = 1'b0; cfg_if.cfg_sel_i = '0;
        cfg_if.cfg_kr_i = '0; cfg_if.cfg_kb_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_kr", kr_o, 39191);
        chk("reset_kb", kb_o, 14942);
        chk("reset_busy", cfg_if.busy_o, 0);
        chk("reset_cnt", apply_cnt_o, 0);
        chk("reset_ack", cfg_if.cfg_ack_o, 0);

        foreach (vt[i])
            txn($sformatf("vec%0d", i), vt[i].sel, vt[i].kr, vt[i].kb, vt[i].v1,
                vt[i].v2, vt[i].xr, vt[i].err, vt[i].ekr, vt[i].ekb, vt[i].en, 0);

        for (int i = 0; i < 30; i++) begin
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                kr = $urandom_range(0, 131071); kb = $urandom_range(0, 131071);
            end else begin
                t = 18'($urandom); kr = int'($signed(t));
                t = 18'($urandom); kb = int'($signed(t));
            end
            v1 = $urandom_range(2, 40);
            stray = ($urandom_range(0, 1) == 1);
            xr = stray ? $urandom_range(1, 3) : 0;
            model(sel, kr, kb, err, ekr, ekb);
            txn($sformatf("rnd%0d", i), sel, kr, kb, v1, 0, xr, err, ekr, ekb,
                err ? 2 : v1 + 1, 0);
        end

        // Reset while a request waits for vs: no ack, outputs back to BT.601.
        @(negedge clk);
        cfg_if.cfg_sel_i = 2'b11; cfg_if.cfg_req_i = 1'b1;
        @(negedge clk);
        cfg_if.cfg_req_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_before", cfg_if.busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_kr", kr_o, 39191);
        chk("midrst_kb", kb_o, 14942);
        chk("midrst_busy", cfg_if.busy_o, 0);
        chk("midrst_cnt", apply_cnt_o, 0);
        rst = 1'b0;
        m_kr = 39191; m_kb = 14942; m_cnt = 0;
        begin
            bit saw_ack;
            saw_ack = 0;
            for (int i = 0; i < 12; i++) begin
                vs_i = (i == 3);
                @(negedge clk);
                if (cfg_if.cfg_ack_o !== 1'b0) saw_ack = 1;
            end
            chk("midrst_no_ack", saw_ack, 0);
            chk("midrst_kr_after", kr_o, 39191);
        end
        txn("post_rst", 2'b01, 0, 0, 6, 0, 0, 0, 27866, 9463, 7, 0);

`ifdef RGB2Y_CFG_TIMEOUT_EN
        // WAIT_VS starts at n=2, so its 100th cycle is n=101 and acks at n=102.
        txn("to_force", 2'b00, 0, 0, 0, 0, 0, 0, 39191, 14942, 102, 1);
        txn("to_vs40", 2'b01, 0, 0, 41, 0, 0, 0, 27866, 9463, 42, 0);
        txn("to_same", 2'b11, 0, 0, 101, 0, 0, 0, 0, 0, 102, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb2y_coef_ctrl.md
Name: rgb2y_coef_ctrl

Overview:
- Configuration controller for the RGB-to-luma datapath: owns the Kr/Kb coefficient inputs, which are Q1.17 signed 18-bit values, with Y = Kr(R-G) + Kb(B-G) + G.
- Accepts coefficient-change requests from the host/register side, validates them, and applies them only on a frame boundary (rising edge of vs_i).
- A frame is therefore never converted with mixed coefficients.
- Sits beside the converter and drives its kr_i/kb_i directly.

Parameters:
- TIMEOUT_CYC, 2000000: WAIT_VS cycles before a forced apply. Used only with the optional feature.
- CNT_W, 16: width of the apply counter.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- cfg_req_i  in  1  single-cycle request pulse
- cfg_sel_i  in  2  00 BT.601, 01 BT.709, 10 custom, 11 G-only
- cfg_kr_i  in  18  signed custom Kr, Q1.17; used only when sel=10
- cfg_kb_i  in  18  signed custom Kb, Q1.17; used only when sel=10
- vs_i  in  1  vertical sync of the converter input stream, active high
- kr_o  out  18  signed coefficient to the converter
- kb_o  out  18  signed coefficient to the converter
- cfg_ack_o  out  1  one-cycle completion pulse
- cfg_err_o  out  1  valid only with cfg_ack_o; 1 = request rejected
- busy_o  out  1  request pending
- apply_cnt_o  out  CNT_W  number of applied configurations

Behaviour:
- Reset values:
  - kr_o=39191, kb_o=14942 (BT.601).
  - cfg_ack_o=0, cfg_err_o=0, busy_o=0, apply_cnt_o=0.
  - FSM=IDLE, vs_d=1. vs_d=1 prevents a false edge if vs_i is high when reset releases.
- Coefficient table:
  - BT.601: Kr=39191, Kb=14942.
  - BT.709: Kr=27866, Kb=9463.
  - G-only: Kr=0, Kb=0.
  - Custom: cfg_kr_i/cfg_kb_i as given.
- Edge detect: vs_d <= vs_i every cycle. vs_rise = vs_i & ~vs_d.
- IDLE:
  - On cfg_req_i, latch sel, kr and kb into pending registers.
  - Compute a 19-bit sum kr+kb.
  - Go to CHECK; busy_o=1 from the next cycle.
- CHECK (exactly 1 cycle):
  - A request is invalid when sel=10 and (kr<0, or kb<0, or kr+kb>131072).
  - Invalid: cfg_ack_o=1 and cfg_err_o=1 for one cycle, busy_o=0, back to IDLE. Coefficient outputs are untouched.
  - Valid: go to WAIT_VS.
  - A vs_rise during CHECK is not used; the request waits for the next frame.
- WAIT_VS, at the clock edge that samples vs_rise=1:
  - kr_o/kb_o <= pending values.
  - apply_cnt_o increments, wrapping from 2^CNT_W-1 to 0.
  - cfg_ack_o=1 and cfg_err_o=0 for one cycle.
  - busy_o=0; back to IDLE.
- Latency from request pulse:
  - Rejection: ack 2 cycles after the request.
  - Apply: ack no earlier than 3 cycles after the request.
- cfg_req_i while busy_o=1 is ignored: no ack, pending registers unchanged.
- cfg_req_i in the same cycle as an ack is ignored. A new request is accepted only once the FSM is in IDLE.
- cfg_sel_i, cfg_kr_i and cfg_kb_i are sampled only in the request cycle.
- Reset mid-request: the pending request is discarded and all outputs return to their reset values. No ack is ever issued for a discarded request.
- kr_o/kb_o change only at reset or at an apply edge. They are stable for a whole frame.

Optional Feature:
- Macro: RGB2Y_CFG_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_VS; it is cleared on entry to WAIT_VS.
  - If it reaches TIMEOUT_CYC-1 with no vs_rise, apply exactly as on vs_rise.
  - Port timeout_o (out, 1) pulses together with that ack.
  - A vs_rise in the same cycle as the timeout counts as a normal apply: timeout_o=0.
- Undefined:
  - No counter and no timeout_o port.
  - WAIT_VS waits indefinitely for vs_rise.

Test Plan:
1. Reset, then idle 10 cycles -> kr_o=39191, kb_o=14942, busy_o=0, apply_cnt_o=0, no ack.
2. Request sel=01, then vs_i rises 50 cycles later -> kr_o/kb_o stay 39191/14942 until the sampling edge, then become 27866/9463. One ack with err=0; apply_cnt_o=1; busy_o high between request and ack.
3. Request sel=10, kr=100000, kb=40000 -> ack+err 2 cycles after the request; outputs unchanged; busy_o back to 0.
4. Request sel=10, kr=-5, kb=10 -> rejected. Then sel=10, kr=65536, kb=65536 (sum exactly 131072) -> accepted and applied at the next vs_rise.
5. Request sel=11, then a second request sel=00 while busy, then vs_rise -> kr_o=kb_o=0, exactly one ack. Assert rst while a later request is pending -> no ack; outputs return to BT.601.
6. With RGB2Y_CFG_TIMEOUT_EN, TIMEOUT_CYC=100, request sel=01 and hold vs_i low -> apply and ack on the 100th WAIT_VS cycle with timeout_o=1. Repeat with vs_rise at cycle 40 -> apply at 40, timeout_o=0.
